// File: rtl/nibble_serial_subtractor.sv
// ============================================================================
//  Module      : nibble_serial_subtractor
//  Description : Digit-serial subtractor. Computes in1 - in2 over N bits,
//                one W-bit digit per clock, LSB digit first, with valid/ready
//                handshakes on both sides. Optional macro ADD_SUB_SEL_EN adds
//                a 'sub' port selecting addition (sub=0) or subtraction.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nibble_serial_subtractor #(
    parameter int N = 32,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
`ifdef ADD_SUB_SEL_EN
    input  logic         sub,
`endif
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in1,
    input  logic [N-1:0] in2,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] diff,
    output logic         bout,
    output logic         of
);

    localparam int DIGITS = N / W;
    localparam int CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] c_last_digit = CNT_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [N-1:0]     r_a;        // minuend, shifted right one digit per cycle
    logic [N-1:0]     r_b;        // second operand, shifted alongside r_a
    logic [N-1:0]     r_partial;  // result digits shifted in from the top
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;

    logic             w_sub;      // operation captured with the operands
    logic             w_sub_in;   // operation presented with new operands
    logic             w_accept;
    logic [W-1:0]     w_b_dig;
    logic [W:0]       w_sum;
    logic [N-1:0]     w_partial_next;
    logic             w_bout;
    logic             w_of;

`ifdef ADD_SUB_SEL_EN
    logic r_sub;
    assign w_sub    = r_sub;
    assign w_sub_in = sub;
`else
    localparam logic c_sub = 1'b1;
    assign w_sub    = c_sub;
    assign w_sub_in = c_sub;
`endif

    // Ready is open in IDLE, and in DONE only while the current result drains
    assign in_ready = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
    assign w_accept = in_valid && in_ready;

    // One digit of a + ~b + c (or a + b + c for addition)
    assign w_b_dig        = w_sub ? ~r_b[W-1:0] : r_b[W-1:0];
    assign w_sum          = {1'b0, r_a[W-1:0]} + {1'b0, w_b_dig} + {{W{1'b0}}, r_carry};
    assign w_partial_next = {w_sum[W-1:0], r_partial[N-1:W]};

    // Flags are only meaningful on the final (most significant) digit, where
    // r_a[W-1]/r_b[W-1] hold the operand sign bits and w_sum[W-1] the result sign
    assign w_bout = w_sum[W] ^ w_sub;
    assign w_of   = (r_a[W-1] ^ r_b[W-1] ^ ~w_sub) & (r_a[W-1] ^ w_sum[W-1]);

    // Control FSM, digit datapath and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_partial <= '0;
            r_carry   <= 1'b0;
            r_cnt     <= '0;
            out_valid <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
            of        <= 1'b0;
`ifdef ADD_SUB_SEL_EN
            r_sub     <= 1'b1;
`endif
        end else if (w_accept) begin
            // Accepting from IDLE or back-to-back from DONE; outputs keep
            // the previous result, only out_valid drops
            r_a       <= in1;
            r_b       <= in2;
            r_carry   <= w_sub_in;
            r_cnt     <= '0;
            out_valid <= 1'b0;
            r_state   <= S_BUSY;
`ifdef ADD_SUB_SEL_EN
            r_sub     <= sub;
`endif
        end else begin
            case (r_state)
                S_BUSY: begin
                    r_a       <= r_a >> W;
                    r_b       <= r_b >> W;
                    r_partial <= w_partial_next;
                    r_carry   <= w_sum[W];
                    r_cnt     <= r_cnt + 1'b1;
                    if (r_cnt == c_last_digit) begin
                        diff      <= w_partial_next;
                        bout      <= w_bout;
                        of        <= w_of;
                        out_valid <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_subtractor.sv
// ============================================================================
//  Module      : tb_nibble_serial_subtractor
//  Description : Self-checking bench for nibble_serial_subtractor using
//                directed corner cases plus randomized operands against an
//                arithmetic reference model. Honours ADD_SUB_SEL_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nibble_serial_subtractor;

    localparam int N       = 32;
    localparam int W       = 4;
    localparam int LATENCY = N / W;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in1;
    logic [N-1:0] in2;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] diff;
    logic         bout;
    logic         of;
`ifdef ADD_SUB_SEL_EN
    logic         sub;
`endif

    int n_checks;
    int n_fail;

    nibble_serial_subtractor #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef ADD_SUB_SEL_EN
        .sub       (sub),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .of        (of)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands
    function automatic logic [N+1:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic s);
        longint       sa;
        longint       sb;
        longint       sres;
        logic [N:0]   ures;
        logic         f_bout;
        logic         f_of;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (s) begin
            ures   = {1'b0, a} - {1'b0, b};
            f_bout = (a < b);
            sres   = sa - sb;
        end else begin
            ures   = {1'b0, a} + {1'b0, b};
            f_bout = ures[N];
            sres   = sa + sb;
        end
        f_of = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
        return {f_of, f_bout, ures[N-1:0]};
    endfunction

    // Present operands and complete the accept edge; inputs are scrambled afterwards
    task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
        @(negedge clk);
        in1       = a;
        in2       = b;
        in_valid  = 1'b1;
        out_ready = 1'b1;
`ifdef ADD_SUB_SEL_EN
        sub       = s;
`endif
        #1;
        check("accept_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in1       = $urandom;
        in2       = $urandom;
`ifdef ADD_SUB_SEL_EN
        sub       = $urandom_range(0, 1);
`endif
    endtask

    // Count edges until out_valid, then compare the result with the model
    task automatic wait_result(input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
        logic [N+1:0] exp;
        int           cyc;
        exp = model(a, b, s);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!out_valid && cyc < 3 * LATENCY);
        check("latency", 64'(cyc), 64'(LATENCY));
        check("diff", {32'd0, diff}, {32'd0, exp[N-1:0]});
        check("bout", {63'd0, bout}, {63'd0, exp[N]});
        check("of",   {63'd0, of},   {63'd0, exp[N+1]});
        check("busy_blocked", {63'd0, in_ready}, 64'd0);
    endtask

    // Drain the result and confirm the block returns to idle with outputs held
    task automatic drain(input logic [N-1:0] held);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("idle_valid", {63'd0, out_valid}, 64'd0);
        check("idle_ready", {63'd0, in_ready}, 64'd1);
        check("idle_hold", {32'd0, diff}, {32'd0, held});
    endtask

    task automatic full_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
        logic [N+1:0] exp;
        exp = model(a, b, s);
        start_op(a, b, s);
        wait_result(a, b, s);
        drain(exp[N-1:0]);
    endtask

    function automatic logic [N-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        logic         rs;
        logic [N-1:0] held;
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in1       = '0;
        in2       = '0;
`ifdef ADD_SUB_SEL_EN
        sub       = 1'b1;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  {63'd0, in_ready},  64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_diff",      {32'd0, diff},      64'd0);
        check("rst_bout",      {63'd0, bout},      64'd0);
        check("rst_of",        {63'd0, of},        64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed corners
        full_op(32'h0000_0005, 32'h0000_0003, 1'b1);
        full_op(32'h0000_0000, 32'h0000_0001, 1'b1);
        full_op(32'h8000_0000, 32'h0000_0001, 1'b1);
        full_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1);

        // Backpressure: result must hold and nothing be accepted
        start_op(32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
        wait_result(32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
        held = diff;
        @(negedge clk);
        in1      = 32'h0000_1000;
        in2      = 32'h0000_2000;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_valid", {63'd0, out_valid}, 64'd1);
            check("bp_ready", {63'd0, in_ready},  64'd0);
            check("bp_diff",  {32'd0, diff},      {32'd0, held});
        end
        // Raising out_ready accepts the waiting operands on the same edge
        start_op(32'h0000_1000, 32'h0000_2000, 1'b1);
        wait_result(32'h0000_1000, 32'h0000_2000, 1'b1);
        drain(32'hFFFF_F000);

        // Reset in the middle of an operation
        start_op(32'hAAAA_AAAA, 32'h5555_5555, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        check("mid_rst_diff",  {32'd0, diff},      64'd0);
        check("mid_rst_ready", {63'd0, in_ready},  64'd1);
        @(negedge clk);
        rst = 1'b0;
        full_op(32'h1234_5678, 32'h0234_5679, 1'b1);

`ifdef ADD_SUB_SEL_EN
        full_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        full_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
`endif

        // Randomized operands, with back-to-back accepts on odd iterations
        for (int i = 0; i < 30; i++) begin
            ra = pick();
            rb = pick();
`ifdef ADD_SUB_SEL_EN
            rs = 1'($urandom_range(0, 1));
`else
            rs = 1'b1;
`endif
            start_op(ra, rb, rs);
            wait_result(ra, rb, rs);
            if (i % 2 == 1) begin
                held = model(ra, rb, rs);
                drain(held);
            end
        end
        drain(model(ra, rb, rs));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Absolute time bound so the run always terminates
    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
